// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and access-size helpers for lsu_mem_if.
package lsu_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  function automatic logic [3:0] lane_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3, input logic xlen64);
    return is_store ? (!funct3[2] && (funct3 != SD || xlen64))
                    : ((funct3 == LD || funct3 == LWU) ? xlen64 : funct3 != 3'b111);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane steering, byte-enable generation and load shift/extend.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                funct3,
  input  logic [$clog2(XLEN/8)-1:0] lane,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata,
  output logic [XLEN/8-1:0]         byte_en,
  output logic [XLEN-1:0]           wdata_lane,
  output logic [XLEN-1:0]           rdata_ext
);
  localparam int NB = XLEN / 8;
  logic [3:0]              size;
  logic [$clog2(XLEN)-1:0] sh;
  logic [XLEN-1:0]         rsh;
  logic [XLEN-1:0]         mask;
  logic                    sgn;
  always_comb begin
    size = lane_bytes(funct3);
    sh = {lane, 3'b000};
    byte_en = (size == 4'd1 ? NB'(1) : size == 4'd2 ? NB'(3) : size == 4'd4 ? NB'(15) : {NB{1'b1}}) << lane;
    wdata_lane = wdata << sh;
    rsh = rdata >> sh;
    mask = size == 4'd1 ? XLEN'(8'hFF) : size == 4'd2 ? XLEN'(16'hFFFF) : size == 4'd4 ? XLEN'(32'hFFFF_FFFF) : '1;
    sgn = !funct3[2] && (size == 4'd1 ? rsh[7] : size == 4'd2 ? rsh[15] : size == 4'd4 ? rsh[31] : 1'b0);
    rdata_ext = (rsh & mask) | ({XLEN{sgn}} & ~mask);
  end
endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: multi-cycle RISC-V load/store unit with byte-lane steering and a ready timeout.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned accesses into errors instead of aligning them down.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  output logic              rsp_is_load,
  output logic [4:0]        rsp_rd,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err,
  output logic              lsu_busy,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              dmem_wen,
  output logic              dmem_ren,
  output logic [XLEN/8-1:0] byte_en,
  input  logic              dmem_ready
);
  localparam int LANE_W = $clog2(XLEN / 8);
  localparam int TW = $clog2(TIMEOUT + 2);

  state_t              state, state_nx;
  logic                st_q, err_q;
  logic [4:0]          rd_q;
  logic [2:0]          f3_q;
  logic [LANE_W-1:0]   lane_q;
  logic [XLEN-1:0]     data_q;
  logic [TW-1:0]       tcnt;
  logic [3:0]          size;
  logic [ADDR_W-1:0]   amask, aligned;
  logic                legal, misal, bad, tout;
  logic [2:0]          al_f3;
  logic [LANE_W-1:0]   al_lane;
  logic [XLEN/8-1:0]   al_be;
  logic [XLEN-1:0]     al_wdata, al_rdata;

  always_comb begin
    size = lane_bytes(req_funct3);
    amask = ADDR_W'(size - 4'd1);
    aligned = req_addr & ~amask;
    legal = funct3_legal(req_is_store, req_funct3, XLEN == 64);
    misal = |(req_addr & amask);
`ifdef LSU_MISALIGN_TRAP_EN
    bad = !legal || misal;
`else
    bad = !legal;
`endif
    tout = TIMEOUT > 0 && !dmem_ready && tcnt == TW'(TIMEOUT - 1);
    al_f3 = state == IDLE ? req_funct3 : f3_q;
    al_lane = state == IDLE ? aligned[LANE_W-1:0] : lane_q;
  end

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_f3),
    .lane       (al_lane),
    .wdata      (req_wdata),
    .rdata      (dmem_rdata),
    .byte_en    (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state == IDLE   ? (req_valid ? (bad ? RESP : ACCESS) : IDLE)
             : state == ACCESS ? ((dmem_ready || tout) ? RESP : ACCESS)
             : IDLE;
  end

  always_comb begin
    req_ready = state == IDLE;
    lsu_busy = state != IDLE;
    dmem_ren = state == ACCESS && !st_q;
    dmem_wen = state == ACCESS && st_q;
    rsp_valid = state == RESP;
    rsp_is_load = rsp_valid && !st_q;
    rsp_rd = rsp_valid ? rd_q : '0;
    rsp_err = rsp_valid && err_q;
    rsp_data = (rsp_valid && !err_q) ? data_q : '0;
  end

  // Request fields are captured once at accept and stay stable for the whole access.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= 1'b0;
      err_q <= 1'b0;
      rd_q <= '0;
      f3_q <= '0;
      lane_q <= '0;
      data_q <= '0;
      tcnt <= '0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      byte_en <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        st_q <= req_is_store;
        err_q <= bad;
        rd_q <= req_rd;
        f3_q <= req_funct3;
        lane_q <= aligned[LANE_W-1:0];
        data_q <= '0;
        if (!bad) begin
          dmem_addr <= {aligned[ADDR_W-1:LANE_W], LANE_W'(0)};
          dmem_wdata <= al_wdata;
          byte_en <= al_be;
        end
      end
      if (state == ACCESS) begin
        tcnt <= (dmem_ready || tout) ? '0 : tcnt + TW'(1);
        if (dmem_ready) data_q <= st_q ? '0 : al_rdata;
        else if (tout) err_q <= 1'b1;
      end
    end
endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
Parametrised load/store unit that replaces the single-cycle, fixed-width MEM-stage logic of the pipelined RISC-V core.
- Accepts one load/store per handshake from EX/MEM.
- Drives a split-data, multi-cycle data-memory port with address-correct byte-lane steering.
- Returns sign/zero-extended load data or store completion to writeback.
- Exposes a busy signal for the hazard unit to stall the pipeline.

Parameters:
XLEN, 32, data path width; legal values 32 or 64.
ADDR_W, 32, byte address width.
TIMEOUT, 16, wait cycles for dmem_ready before abort; 0 disables timeout.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 of the load/store
req_addr  in  ADDR_W  effective byte address
req_wdata  in  XLEN  store data, right-aligned
req_rd  in  5  load destination register
rsp_valid  out  1  one-cycle completion pulse
rsp_is_load  out  1  completion belongs to a load
rsp_rd  out  5  destination register of the completion
rsp_data  out  XLEN  extended load data; 0 for stores and errors
rsp_err  out  1  access aborted
lsu_busy  out  1  request in flight; stall EX/MEM
dmem_addr  out  ADDR_W  word-aligned address (low log2(XLEN/8) bits zero)
dmem_wdata  out  XLEN  lane-steered store data
dmem_rdata  in  XLEN  read data, valid when dmem_ready=1
dmem_wen  out  1  write strobe
dmem_ren  out  1  read strobe
byte_en  out  XLEN/8  active byte lanes
dmem_ready  in  1  memory completes the current access this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; req_ready=1 once reset is released. Every other output and the timeout counter are 0.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid: latch the request, decode it, go to ACCESS. If the request is illegal or misaligned-trapped, go straight to RESP with err=1.
  - ACCESS: dmem_ren/dmem_wen, addr, wdata and byte_en are registered and held stable until dmem_ready=1. On dmem_ready: capture rdata, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Minimum latency: accept in cycle N; strobes asserted in N+1. With dmem_ready=1 in N+1, rsp_valid is high in N+2.
- req_ready = (state==IDLE); lsu_busy = !req_ready. No response backpressure: writeback always accepts.
- Lane select: lane = addr[log2(XLEN/8)-1:0].
  - Byte: byte_en = 1<<lane.
  - Half: byte_en = 2'b11<<lane.
  - Word: byte_en = 4'hF<<lane.
  - Double: byte_en all ones.
  - dmem_wdata = req_wdata shifted left by lane*8.
- Load extraction: rdata shifted right by lane*8, then:
  - LB/LH/LW sign-extend.
  - LBU/LHU/LWU zero-extend.
  - LD passes through.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101; plus 011 and 110 only when XLEN=64.
  - Stores: 000, 001, 010; plus 011 only when XLEN=64.
  - Any other funct3: no memory access, rsp_err=1.
- Misaligned access (address not a multiple of the access size), with LSU_MISALIGN_TRAP_EN undefined: the low address bits are forced to 0, the access proceeds, and rsp_err=0.
- Timeout (TIMEOUT>0): the counter increments each ACCESS cycle without dmem_ready. When the count reaches TIMEOUT:
  - drop the strobes;
  - go to RESP with rsp_err=1 and rsp_data=0.
- Errored store: no write strobe is ever asserted.
- req_valid while busy is ignored; the requester must hold it.
- Reset mid-access: strobes drop asynchronously; no response is issued for the dropped request.

Optional Feature:
LSU_MISALIGN_TRAP_EN:
- Defined: a misaligned request performs no memory access. rsp_valid and rsp_err=1 occur in cycle N+1.
- Undefined: misaligned requests are silently aligned down as described in Behaviour.

Decomposition:
lsu_pkg holds:
- funct3 localparams (LB..LD, SB..SD);
- the state enum {IDLE, ACCESS, RESP};
- the lane-width function that maps funct3 to a byte count.

Sub-module lsu_lane_align: combinational store-lane steering, byte_en generation, and load shift/extend, parametrised by XLEN.

Test Plan:
1. XLEN=32. SB addr 0x1003, wdata 0x000000A5, dmem_ready=1 immediately → byte_en=1000, dmem_wdata=0xA5xxxxxx, dmem_addr=0x1000; store rsp_valid in N+2 with rsp_data=0.
2. LH addr 0x2002, rdata 0x8001_1234 → rsp_data 0xFFFF8001. LHU at the same address → 0x00008001.
3. LW with dmem_ready delayed 5 cycles → strobes held stable 6 cycles; req_ready=0 throughout; rsp_valid at N+7.
4. TIMEOUT=4, dmem_ready never asserted → strobes drop after 4 ACCESS cycles; rsp_err=1, rsp_data=0.
5. LW addr 0x3001:
   - without LSU_MISALIGN_TRAP_EN → dmem_addr=0x3000, rsp_err=0;
   - with LSU_MISALIGN_TRAP_EN → no strobe, rsp_err=1 at N+1.
6. Assert rst_n=0 mid-ACCESS → dmem_ren=0 immediately; after release req_ready=1 and no stale rsp_valid. XLEN=64 LD at 0x8 returns rdata unchanged.
